axi_sram_slave: RTL and testbench

//  AXI3 responder backed by an on-chip word-addressed memory array; serves the cache-side AXI master bridge in

---
 rtl/axi_sram_slave_if.sv | 63 ++++++
 rtl/axi_sram_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the cache-side master bridge and the on-chip SRAM responder.
// Read (AR/R) and write (AW/W/B) channels, 4-bit ids, 32-bit data.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder over a word-addressed SRAM; independent read/write FSMs, one burst per direction.
// Define AXI_SLV_RD_DELAY_EN to insert RD_DELAY wait cycles before the first read beat.
module axi_sram_slave #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned AW_IDX   = 10,
    parameter int unsigned RD_DELAY = 2
) (
    input logic             clk,
    input logic             resetn,
    axi_sram_slave_if.slave bus
);

    typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    if (DEPTH != (1 << AW_IDX)) begin : gen_bad_depth
        $error("DEPTH must equal 2**AW_IDX");
    end
    if (RD_DELAY < 1 || RD_DELAY > 15) begin : gen_bad_delay
        $error("RD_DELAY must be within 1..15");
    end

    logic [31:0] mem [DEPTH];

    function automatic logic [31:0] next_addr(logic [31:0] addr, logic [2:0] size,
                                              logic [1:0] burst);
        logic [2:0] eff;
        eff = (size > 3'd2) ? 3'd2 : size;
        if (burst == 2'b00) return addr;
        return addr + (32'd1 << eff);
    endfunction

    function automatic logic in_range(logic [31:0] addr);
        return addr[31:AW_IDX+2] == '0;
    endfunction

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_id_q, r_id_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [2:0]  r_size_q, r_size_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic [7:0]  r_beat_q, r_beat_d;
    logic [AW_IDX-1:0] r_idx;
`ifdef AXI_SLV_RD_DELAY_EN
    logic [3:0]  r_wait_q, r_wait_d;
`endif

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_id_q, w_id_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [7:0]  w_beat_q, w_beat_d;
    logic        w_err_q, w_err_d;
    logic        w_over_q, w_over_d;
    logic [AW_IDX-1:0] w_idx;
    logic        mem_we;
    logic        w_drop;

    assign r_idx = r_addr_q[AW_IDX+1:2];
    assign w_idx = w_addr_q[AW_IDX+1:2];

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
`ifdef AXI_SLV_RD_DELAY_EN
        r_wait_d  = r_wait_q;
`endif
        bus.arready = (r_state_q == RIdle);
        bus.rvalid  = (r_state_q == RData);
        bus.rid     = r_id_q;
        bus.rlast   = bus.rvalid && (r_beat_q == r_len_q);
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        if (bus.rvalid) begin
            if (in_range(r_addr_q)) bus.rdata = mem[r_idx];
            else                    bus.rresp = 2'b10;
        end

        case (r_state_q)
            RIdle: begin
                if (bus.arvalid) begin
                    r_id_d    = bus.arid;
                    r_addr_d  = bus.araddr;
                    r_len_d   = bus.arlen;
                    r_size_d  = bus.arsize;
                    r_burst_d = bus.arburst;
                    r_beat_d  = '0;
`ifdef AXI_SLV_RD_DELAY_EN
                    r_wait_d  = 4'(RD_DELAY - 1);
                    r_state_d = RWait;
`else
                    r_state_d = RData;
`endif
                end
            end
`ifdef AXI_SLV_RD_DELAY_EN
            RWait: begin
                if (r_wait_q == '0) r_state_d = RData;
                else                r_wait_d  = r_wait_q - 4'd1;
            end
`endif
            RData: begin
                if (bus.rready) begin
                    r_beat_d = r_beat_q + 8'd1;
                    r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
                    if (bus.rlast) r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        w_over_d  = w_over_q;
        mem_we    = 1'b0;
        w_drop    = w_over_q || !in_range(w_addr_q);
        bus.awready = (w_state_q == WIdle);
        bus.wready  = (w_state_q == WData);
        bus.bvalid  = (w_state_q == WResp);
        bus.bid     = w_id_q;
        bus.bresp   = (bus.bvalid && w_err_q) ? 2'b10 : 2'b00;

        case (w_state_q)
            WIdle: begin
                if (bus.awvalid) begin
                    w_id_d    = bus.awid;
                    w_addr_d  = bus.awaddr;
                    w_len_d   = bus.awlen;
                    w_size_d  = bus.awsize;
                    w_burst_d = bus.awburst;
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                    w_over_d  = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (bus.wvalid) begin
                    mem_we   = !w_drop;
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    if (w_drop) w_err_d = 1'b1;
                    // Past the final announced beat: drop everything until wlast arrives.
                    if (!w_over_q) begin
                        w_beat_d = w_beat_q + 8'd1;
                        if (w_beat_q == w_len_q && !bus.wlast) w_over_d = 1'b1;
                    end
                    if (bus.wlast) w_state_d = WResp;
                end
            end
            WResp: begin
                if (bus.bready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
`ifdef AXI_SLV_RD_DELAY_EN
            r_wait_q  <= '0;
`endif
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            w_over_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
`ifdef AXI_SLV_RD_DELAY_EN
            r_wait_q  <= r_wait_d;
`endif
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
            w_over_q  <= w_over_d;
        end
    end

    // Contents survive reset; a read of the word being written sees the old value this cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single-beat vector table plus burst, backpressure,
// overflow, concurrency and reset sequences. Honours AXI_SLV_RD_DELAY_EN for read latency.
module tb_axi_sram_slave;
    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned AW_IDX   = 10;
    localparam int unsigned RD_DELAY = 2;
`ifdef AXI_SLV_RD_DELAY_EN
    localparam int LAT = RD_DELAY + 1;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    axi_sram_slave_if bus ();

    axi_sram_slave #(
        .DEPTH   (DEPTH),
        .AW_IDX  (AW_IDX),
        .RD_DELAY(RD_DELAY)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] got_data[16];
    logic [1:0]  got_resp[16];
    logic        got_last[16];
    logic [3:0]  got_id  [16];
    logic [1:0]  got_bresp;
    logic [3:0]  got_bid;
    int          first_wait;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arburst = burst; bus.arvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clk); #1; n++; end
        if (!bus.arready) check("arready_timeout", 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        #1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!bus.rvalid && n < 50) begin @(negedge clk); #1; n++; end
            if (b == 0) first_wait = n;
            if (!bus.rvalid) begin
                check("rvalid_timeout", 32'(bus.rvalid), 32'd1);
                return;
            end
            got_data[b] = bus.rdata;
            got_resp[b] = bus.rresp;
            got_last[b] = bus.rlast;
            got_id[b]   = bus.rid;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int nbeats);
        int n;
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2;
        bus.awburst = burst; bus.awvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge clk); #1; n++; end
        if (!bus.awready) check("awready_timeout", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bus.wdata = wr_data[b]; bus.wstrb = wr_strb[b];
            bus.wlast = (b == nbeats - 1); bus.wvalid = 1'b1;
            #1;
            n = 0;
            while (!bus.wready && n < 50) begin @(negedge clk); #1; n++; end
            if (!bus.wready) check("wready_timeout", 32'(bus.wready), 32'd1);
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        #1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clk); #1; n++; end
        if (!bus.bvalid) check("bvalid_timeout", 32'(bus.bvalid), 32'd1);
        got_bresp = bus.bresp;
        got_bid   = bus.bid;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'b01;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_wready",  32'(bus.wready),  32'd0);
        check("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("rst_rlast",   32'(bus.rlast),   32'd0);
        check("rst_ids",     {24'd0, bus.rid, bus.bid}, 32'd0);
        check("rst_resps",   {28'd0, bus.rresp, bus.bresp}, 32'd0);
        check("rst_rdata",   bus.rdata, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        vecs[0]  = '{1'b1, 32'h10,   32'h11223344, 4'hF, 32'h0,        2'b00, "t3_pre"};
        vecs[1]  = '{1'b1, 32'h10,   32'hAABBCCDD, 4'h5, 32'h0,        2'b00, "t3_strb0101"};
        vecs[2]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'h11BB33DD, 2'b00, "t3_rd0101"};
        vecs[3]  = '{1'b1, 32'h18,   32'h11223344, 4'hF, 32'h0,        2'b00, "t3b_pre"};
        vecs[4]  = '{1'b1, 32'h18,   32'hAABBCCDD, 4'h4, 32'h0,        2'b00, "t3b_strb0100"};
        vecs[5]  = '{1'b0, 32'h18,   32'h0,        4'h0, 32'h11BB3344, 2'b00, "t3b_rd0100"};
        vecs[6]  = '{1'b1, 32'h14,   32'hDEADBEEF, 4'hF, 32'h0,        2'b00, "w14"};
        vecs[7]  = '{1'b1, 32'h14,   32'h00000000, 4'h0, 32'h0,        2'b00, "w14_nostrb"};
        vecs[8]  = '{1'b0, 32'h14,   32'h0,        4'h0, 32'hDEADBEEF, 2'b00, "r14"};
        vecs[9]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        2'b00, "w0"};
        vecs[10] = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        2'b10, "t5_w_oor"};
        vecs[11] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 2'b00, "t5_alias_kept"};
        vecs[12] = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        2'b10, "t5_r_oor"};
        vecs[13] = '{1'b0, 32'hFFFFFFFC, 32'h0,    4'h0, 32'h0,        2'b10, "r_top"};
        vecs[14] = '{1'b1, 32'hFFC,  32'h0BADCAFE, 4'hF, 32'h0,        2'b00, "w_last_word"};
        vecs[15] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h0BADCAFE, 2'b00, "r_last_word"};

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                wr_data[0] = vecs[i].data;
                wr_strb[0] = vecs[i].strb;
                write_burst(4'h1, vecs[i].addr, 8'd0, 2'b01, 1);
                check({vecs[i].name, "_bresp"}, 32'(got_bresp), 32'(vecs[i].exp_resp));
            end else begin
                read_burst(4'h2, vecs[i].addr, 8'd0, 3'd2, 2'b01);
                check({vecs[i].name, "_rdata"}, got_data[0], vecs[i].exp_data);
                check({vecs[i].name, "_rresp"}, 32'(got_resp[0]), 32'(vecs[i].exp_resp));
                check({vecs[i].name, "_rlast"}, 32'(got_last[0]), 32'd1);
            end
        end

        // 4-beat INCR write then read-back
        for (int b = 0; b < 4; b++) begin wr_data[b] = 32'(b + 1); wr_strb[b] = 4'hF; end
        write_burst(4'h5, 32'h40, 8'd3, 2'b01, 4);
        check("t2_bresp", 32'(got_bresp), 32'd0);
        check("t2_bid", 32'(got_bid), 32'h5);
        read_burst(4'h9, 32'h40, 8'd3, 3'd2, 2'b01);
        check("t2_first_latency", 32'(first_wait), 32'(LAT - 1));
        for (int b = 0; b < 4; b++) begin
            check($sformatf("t2_rdata%0d", b), got_data[b], 32'(b + 1));
            check($sformatf("t2_rlast%0d", b), 32'(got_last[b]), 32'(b == 3));
            check($sformatf("t2_rid%0d", b), 32'(got_id[b]), 32'h9);
        end

        // FIXED read rereads one word; size 1 steps 2 bytes; size 3 behaves as size 2
        read_burst(4'h3, 32'h44, 8'd2, 3'd2, 2'b00);
        check("t6_fixed_first_latency", 32'(first_wait), 32'(LAT - 1));
        for (int b = 0; b < 3; b++) check($sformatf("t6_fixed%0d", b), got_data[b], 32'h2);
        read_burst(4'h3, 32'h40, 8'd1, 3'd1, 2'b01);
        check("size1_beat1", got_data[1], 32'h1);
        read_burst(4'h3, 32'h40, 8'd1, 3'd3, 2'b01);
        check("size3_beat1", got_data[1], 32'h2);
        read_burst(4'h3, 32'h40, 8'd1, 3'd2, 2'b10);
        check("wrap_as_incr", got_data[1], 32'h2);

        // Backpressure on beat 2
        @(negedge clk);
        bus.arid = 4'h7; bus.araddr = 32'h40; bus.arlen = 8'd3; bus.arsize = 3'd2;
        bus.arburst = 2'b01; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        #1;
        for (int n = 0; n < 50 && !bus.rvalid; n++) begin @(negedge clk); #1; end
        check("t4_beat1", bus.rdata, 32'h1);
        @(negedge clk);
        #1;
        check("t4_beat2", bus.rdata, 32'h2);
        bus.rready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("t4_hold_valid%0d", c), 32'(bus.rvalid), 32'd1);
            check($sformatf("t4_hold_data%0d", c), bus.rdata, 32'h2);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        #1;
        check("t4_beat3", bus.rdata, 32'h3);
        @(negedge clk);
        #1;
        check("t4_beat4", bus.rdata, 32'h4);
        check("t4_beat4_last", 32'(bus.rlast), 32'd1);
        @(negedge clk);
        #1;
        check("t4_done", 32'(bus.rvalid), 32'd0);

        // Extra beats past awlen are dropped and flag SLVERR
        wr_data[0] = 32'h77777777; wr_strb[0] = 4'hF;
        write_burst(4'h1, 32'h88, 8'd0, 2'b01, 1);
        wr_data[0] = 32'hA; wr_data[1] = 32'hB; wr_data[2] = 32'hC;
        wr_strb[0] = 4'hF; wr_strb[1] = 4'hF; wr_strb[2] = 4'hF;
        write_burst(4'h2, 32'h80, 8'd1, 2'b01, 3);
        check("ovf_bresp", 32'(got_bresp), 32'h2);
        read_burst(4'h4, 32'h80, 8'd2, 3'd2, 2'b01);
        check("ovf_w0", got_data[0], 32'hA);
        check("ovf_w1", got_data[1], 32'hB);
        check("ovf_untouched", got_data[2], 32'h77777777);

        // FIXED write lands every beat on the same word
        wr_data[0] = 32'h54545454; wr_strb[0] = 4'hF;
        write_burst(4'h1, 32'h54, 8'd0, 2'b01, 1);
        wr_data[0] = 32'h11110000; wr_data[1] = 32'h22220000;
        wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        write_burst(4'h6, 32'h50, 8'd1, 2'b00, 2);
        read_burst(4'h4, 32'h50, 8'd1, 3'd2, 2'b01);
        check("fixw_w50", got_data[0], 32'h22220000);
        check("fixw_w54", got_data[1], 32'h54545454);

        // AR and AW in the same cycle, read and write of one word on the same edge
        wr_data[0] = 32'h0000600D; wr_strb[0] = 4'hF;
        write_burst(4'h1, 32'h60, 8'd0, 2'b01, 1);
        @(negedge clk);
        bus.rready = 1'b0;
        bus.arid = 4'hA; bus.araddr = 32'h60; bus.arlen = 8'd0; bus.arvalid = 1'b1;
        bus.awid = 4'hB; bus.awaddr = 32'h60; bus.awlen = 8'd0; bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        #1;
        check("dual_arready", 32'(bus.arready), 32'd1);
        check("dual_awready", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        #1;
        check("dual_both_taken", {30'd0, bus.arready, bus.awready}, 32'd0);
        for (int n = 0; n < 50 && !bus.rvalid; n++) begin @(negedge clk); #1; end
        bus.wdata = 32'hBEEF0001; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        bus.rready = 1'b1;
        #1;
        check("dual_pre_write_data", bus.rdata, 32'h0000600D);
        check("dual_rid", 32'(bus.rid), 32'hA);
        @(negedge clk);
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        #1;
        check("dual_bvalid", 32'(bus.bvalid), 32'd1);
        check("dual_bid", 32'(bus.bid), 32'hB);
        @(negedge clk);
        read_burst(4'h4, 32'h60, 8'd0, 3'd2, 2'b01);
        check("dual_post_write", got_data[0], 32'hBEEF0001);

        // Reset in the middle of a read burst
        @(negedge clk);
        bus.rready = 1'b0;
        bus.araddr = 32'h40; bus.arlen = 8'd3; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        #1;
        for (int n = 0; n < 50 && !bus.rvalid; n++) begin @(negedge clk); #1; end
        check("t1_mid_rvalid_before", 32'(bus.rvalid), 32'd1);
        resetn = 1'b0;
        #1;
        check("t1_rvalid", 32'(bus.rvalid), 32'd0);
        check("t1_arready", 32'(bus.arready), 32'd1);
        check("t1_awready", 32'(bus.awready), 32'd1);
        check("t1_bvalid", 32'(bus.bvalid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        bus.rready = 1'b1;
        read_burst(4'h4, 32'h40, 8'd0, 3'd2, 2'b01);
        check("t1_mem_kept", got_data[0], 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
